// File: rtl/hazard_controller_if.sv
// Hazard controller bus: ID/EX hazard sources in, pipeline-register controls and statistics out.
// master = pipeline side, slave = hazard_controller.
interface hazard_controller_if;
    logic [4:0]  ID_RS1;
    logic [4:0]  ID_RS2;
    logic        ID_USES_RS1;
    logic        ID_USES_RS2;
    logic [4:0]  EX_RD;
    logic        EX_MEM_READ;
    logic        EX_BRANCH_TAKEN;
    logic        EX_DIV_START;
    logic        PC_WRITE_EN;
    logic        IF_ID_WRITE_EN;
    logic        IF_ID_FLUSH;
    logic        ID_EX_WRITE_EN;
    logic        ID_EX_BUBBLE;
    logic        EX_MEM_BUBBLE;
    logic        DIV_BUSY;
    logic        DIV_DONE;
    logic [15:0] STALL_COUNT;
    logic [15:0] FLUSH_COUNT;

    modport master (
        output ID_RS1, ID_RS2, ID_USES_RS1, ID_USES_RS2,
        output EX_RD, EX_MEM_READ, EX_BRANCH_TAKEN, EX_DIV_START,
        input  PC_WRITE_EN, IF_ID_WRITE_EN, IF_ID_FLUSH,
        input  ID_EX_WRITE_EN, ID_EX_BUBBLE, EX_MEM_BUBBLE,
        input  DIV_BUSY, DIV_DONE, STALL_COUNT, FLUSH_COUNT
    );

    modport slave (
        input  ID_RS1, ID_RS2, ID_USES_RS1, ID_USES_RS2,
        input  EX_RD, EX_MEM_READ, EX_BRANCH_TAKEN, EX_DIV_START,
        output PC_WRITE_EN, IF_ID_WRITE_EN, IF_ID_FLUSH,
        output ID_EX_WRITE_EN, ID_EX_BUBBLE, EX_MEM_BUBBLE,
        output DIV_BUSY, DIV_DONE, STALL_COUNT, FLUSH_COUNT
    );
endinterface

// File: rtl/hazard_controller.sv
// RV32IM five-stage hazard controller: load-use stall, EX branch flush, multi-cycle divide hold.
// Optional stall/flush statistics counters are built only when HAZARD_STATS_EN is defined.
module hazard_controller #(
    parameter int DIV_CYCLES = 32
) (
    input  logic                CLK,
    input  logic                RST,
    hazard_controller_if.slave  hz
);

    typedef enum logic [0:0] {
        ST_RUN = 1'b0,
        ST_DIV = 1'b1
    } state_e;

    // CNT counts the remaining hold cycles after the divide-start cycle.
    localparam logic [5:0] CNT_LOAD = 6'(DIV_CYCLES - 2);

    state_e      state_q;
    state_e      state_d;
    logic [5:0]  cnt_q;
    logic [5:0]  cnt_d;

    logic        load_use_s;
    logic        pc_we_s;
    logic        if_id_we_s;
    logic        if_id_flush_s;
    logic        id_ex_we_s;
    logic        id_ex_bubble_s;
    logic        ex_mem_bubble_s;
    logic        div_busy_s;
    logic        div_done_s;

    function automatic logic load_use_hazard(
        input logic       mem_read,
        input logic [4:0] rd,
        input logic [4:0] rs1,
        input logic [4:0] rs2,
        input logic       uses_rs1,
        input logic       uses_rs2
    );
        return mem_read && (rd != 5'd0) &&
               ((uses_rs1 && (rs1 == rd)) || (uses_rs2 && (rs2 == rd)));
    endfunction

    assign load_use_s = load_use_hazard(hz.EX_MEM_READ, hz.EX_RD, hz.ID_RS1, hz.ID_RS2,
                                        hz.ID_USES_RS1, hz.ID_USES_RS2);

    // Next-state and pipeline control decode
    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        pc_we_s         = 1'b1;
        if_id_we_s      = 1'b1;
        if_id_flush_s   = 1'b0;
        id_ex_we_s      = 1'b1;
        id_ex_bubble_s  = 1'b0;
        ex_mem_bubble_s = 1'b0;
        div_busy_s      = 1'b0;
        div_done_s      = 1'b0;
        if (RST) begin
            pc_we_s         = 1'b0;
            if_id_we_s      = 1'b0;
            id_ex_we_s      = 1'b0;
            if_id_flush_s   = 1'b1;
            id_ex_bubble_s  = 1'b1;
            ex_mem_bubble_s = 1'b1;
            state_d         = ST_RUN;
            cnt_d           = 6'd0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (hz.EX_BRANCH_TAKEN) begin
                        // ID holds a wrong-path instruction, so any load-use match is moot.
                        if_id_flush_s  = 1'b1;
                        id_ex_bubble_s = 1'b1;
                    end else if (hz.EX_DIV_START) begin
                        pc_we_s         = 1'b0;
                        if_id_we_s      = 1'b0;
                        id_ex_we_s      = 1'b0;
                        ex_mem_bubble_s = 1'b1;
                        state_d         = ST_DIV;
                        cnt_d           = CNT_LOAD;
                    end else if (load_use_s) begin
                        pc_we_s        = 1'b0;
                        if_id_we_s     = 1'b0;
                        id_ex_bubble_s = 1'b1;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
                ST_DIV: begin
                    div_busy_s = 1'b1;
                    if (cnt_q != 6'd0) begin
                        pc_we_s         = 1'b0;
                        if_id_we_s      = 1'b0;
                        id_ex_we_s      = 1'b0;
                        ex_mem_bubble_s = 1'b1;
                        cnt_d           = cnt_q - 6'd1;
                    end else begin
                        div_done_s = 1'b1;
                        state_d    = ST_RUN;
                    end
                end
                default: begin
                    state_d = ST_RUN;
                    cnt_d   = 6'd0;
                end
            endcase
        end
    end

    // FSM state and divide down-counter
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_RUN;
            cnt_q   <= 6'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign hz.PC_WRITE_EN    = pc_we_s;
    assign hz.IF_ID_WRITE_EN = if_id_we_s;
    assign hz.IF_ID_FLUSH    = if_id_flush_s;
    assign hz.ID_EX_WRITE_EN = id_ex_we_s;
    assign hz.ID_EX_BUBBLE   = id_ex_bubble_s;
    assign hz.EX_MEM_BUBBLE  = ex_mem_bubble_s;
    assign hz.DIV_BUSY       = div_busy_s;
    assign hz.DIV_DONE       = div_done_s;

`ifdef HAZARD_STATS_EN
    logic [15:0] stall_cnt_q;
    logic [15:0] stall_cnt_d;
    logic [15:0] flush_cnt_q;
    logic [15:0] flush_cnt_d;

    function automatic logic [15:0] sat_inc(input logic [15:0] value, input logic en);
        if (en && (value != 16'hFFFF)) begin
            return value + 16'd1;
        end else begin
            return value;
        end
    endfunction

    // Saturating statistics next-state
    always_comb begin
        stall_cnt_d = sat_inc(stall_cnt_q, !pc_we_s);
        flush_cnt_d = sat_inc(flush_cnt_q, if_id_flush_s);
    end

    // Statistics registers, cleared by reset
    always_ff @(posedge CLK) begin
        if (RST) begin
            stall_cnt_q <= 16'd0;
            flush_cnt_q <= 16'd0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign hz.STALL_COUNT = stall_cnt_q;
    assign hz.FLUSH_COUNT = flush_cnt_q;
`else
    assign hz.STALL_COUNT = 16'd0;
    assign hz.FLUSH_COUNT = 16'd0;
`endif

endmodule

// File: tb/tb_hazard_controller.sv
// Self-checking bench for hazard_controller: two instances (DIV_CYCLES 32 and 2) share one stimulus
// stream and are checked against a cycle-timestamp reference model plus hand-written vectors.
module tb_hazard_controller;

`ifdef HAZARD_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    typedef struct packed {
        logic       rst;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
        logic [4:0] rd;
        logic       mr;
        logic       bt;
        logic       ds;
    } stim_t;

    typedef struct {
        string      name;
        stim_t      s;
        logic [7:0] exp;
    } vec_t;

    // ctrl bits: {PC_WE, IF_ID_WE, IF_ID_FLUSH, ID_EX_WE, ID_EX_BUBBLE, EX_MEM_BUBBLE, DIV_BUSY, DIV_DONE}
    localparam logic [7:0] C_RESET = 8'b0010_1100;
    localparam logic [7:0] C_IDLE  = 8'b1101_0000;
    localparam logic [7:0] C_LU    = 8'b0001_1000;
    localparam logic [7:0] C_FLUSH = 8'b1111_1000;
    localparam logic [7:0] C_HOLD  = 8'b0000_0100;
    localparam logic [7:0] C_DHOLD = 8'b0000_0110;
    localparam logic [7:0] C_DONE  = 8'b1101_0011;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    hazard_controller_if if32 ();
    hazard_controller_if if2 ();

    hazard_controller #(.DIV_CYCLES(32)) u_dut32 (.CLK(clk), .RST(rst), .hz(if32));
    hazard_controller #(.DIV_CYCLES(2))  u_dut2  (.CLK(clk), .RST(rst), .hz(if2));

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int div_end [2];
    int m_stall [2];
    int m_flush [2];
    int dc [2] = '{32, 2};
    logic [7:0] obs32;
    logic [7:0] obs2;

    function automatic stim_t mk(input logic r, input logic [4:0] a, input logic [4:0] b,
                                 input logic ua, input logic ub, input logic [4:0] d,
                                 input logic m, input logic br, input logic dv);
        stim_t s;
        s.rst = r; s.rs1 = a; s.rs2 = b; s.u1 = ua; s.u2 = ub;
        s.rd = d; s.mr = m; s.bt = br; s.ds = dv;
        return s;
    endfunction

    function automatic logic [7:0] ctrl32();
        return {if32.PC_WRITE_EN, if32.IF_ID_WRITE_EN, if32.IF_ID_FLUSH, if32.ID_EX_WRITE_EN,
                if32.ID_EX_BUBBLE, if32.EX_MEM_BUBBLE, if32.DIV_BUSY, if32.DIV_DONE};
    endfunction

    function automatic logic [7:0] ctrl2();
        return {if2.PC_WRITE_EN, if2.IF_ID_WRITE_EN, if2.IF_ID_FLUSH, if2.ID_EX_WRITE_EN,
                if2.ID_EX_BUBBLE, if2.EX_MEM_BUBBLE, if2.DIV_BUSY, if2.DIV_DONE};
    endfunction

    // Reference: a divide started at cycle T keeps EX busy through cycle T+dc-1 (div_end).
    function automatic logic [7:0] model_ctrl(input int k, input stim_t s);
        bit lu;
        lu = s.mr && (s.rd != 5'd0) &&
             ((s.u1 && s.rs1 == s.rd) || (s.u2 && s.rs2 == s.rd));
        if (s.rst)               return C_RESET;
        if (cyc == div_end[k])   return C_DONE;
        if (cyc < div_end[k])    return C_DHOLD;
        if (s.bt)                return C_FLUSH;
        if (s.ds)                return C_HOLD;
        if (lu)                  return C_LU;
        return C_IDLE;
    endfunction

    task automatic model_update(input int k, input stim_t s, input logic [7:0] e);
        if (s.rst) begin
            div_end[k] = -1;
            m_stall[k] = 0;
            m_flush[k] = 0;
        end else begin
            if (!e[7] && m_stall[k] < 65535) m_stall[k]++;
            if (e[5] && m_flush[k] < 65535) m_flush[k]++;
            if (cyc > div_end[k] && !s.bt && s.ds) div_end[k] = cyc + dc[k] - 1;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic drive(input stim_t s);
        rst = s.rst;
        if32.ID_RS1 = s.rs1; if32.ID_RS2 = s.rs2; if32.ID_USES_RS1 = s.u1; if32.ID_USES_RS2 = s.u2;
        if32.EX_RD = s.rd; if32.EX_MEM_READ = s.mr; if32.EX_BRANCH_TAKEN = s.bt; if32.EX_DIV_START = s.ds;
        if2.ID_RS1 = s.rs1; if2.ID_RS2 = s.rs2; if2.ID_USES_RS1 = s.u1; if2.ID_USES_RS2 = s.u2;
        if2.EX_RD = s.rd; if2.EX_MEM_READ = s.mr; if2.EX_BRANCH_TAKEN = s.bt; if2.EX_DIV_START = s.ds;
    endtask

    // One clock: drive, compare mid-cycle against the model (and optional table value), advance model.
    task automatic step(input stim_t s, input bit chk, input bit use_t, input logic [7:0] texp,
                        input string tname);
        logic [7:0] e0;
        logic [7:0] e1;
        drive(s);
        #3;
        e0 = model_ctrl(0, s);
        e1 = model_ctrl(1, s);
        obs32 = ctrl32();
        obs2  = ctrl2();
        if (chk) begin
            check("ctrl_dc32", 32'(obs32), 32'(e0));
            check("ctrl_dc2", 32'(obs2), 32'(e1));
            check("stall_cnt_dc32", 32'(if32.STALL_COUNT), STATS ? 32'(m_stall[0]) : 32'd0);
            check("flush_cnt_dc32", 32'(if32.FLUSH_COUNT), STATS ? 32'(m_flush[0]) : 32'd0);
            check("stall_cnt_dc2", 32'(if2.STALL_COUNT), STATS ? 32'(m_stall[1]) : 32'd0);
            check("flush_cnt_dc2", 32'(if2.FLUSH_COUNT), STATS ? 32'(m_flush[1]) : 32'd0);
        end
        if (use_t) begin
            check({"tbl_", tname, "_dc32"}, 32'(obs32), 32'(texp));
            check({"tbl_", tname, "_dc2"}, 32'(obs2), 32'(texp));
        end
        @(posedge clk);
        model_update(0, s, e0);
        model_update(1, s, e1);
        cyc++;
        #1;
    endtask

    vec_t tbl [11];
    stim_t idle_s;
    stim_t div_s;
    stim_t rs;
    logic [7:0] b2b_exp [4];

    initial begin
        idle_s = mk(1'b0, 5'd1, 5'd2, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0);
        div_s  = mk(1'b0, 5'd1, 5'd2, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b1);
        tbl[0]  = '{"reset",      mk(1'b1, 5'd5, 5'd5, 1'b1, 1'b1, 5'd5, 1'b1, 1'b1, 1'b1), C_RESET};
        tbl[1]  = '{"idle",       idle_s, C_IDLE};
        tbl[2]  = '{"lu_rs2",     mk(1'b0, 5'd3, 5'd5, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0), C_LU};
        tbl[3]  = '{"lu_cleared", idle_s, C_IDLE};
        tbl[4]  = '{"lu_rd0",     mk(1'b0, 5'd3, 5'd0, 1'b0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0), C_IDLE};
        tbl[5]  = '{"rs1_unused", mk(1'b0, 5'd7, 5'd2, 1'b0, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0), C_IDLE};
        tbl[6]  = '{"lu_rs1",     mk(1'b0, 5'd7, 5'd2, 1'b1, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0), C_LU};
        tbl[7]  = '{"flush_prio", mk(1'b0, 5'd3, 5'd5, 1'b0, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0), C_FLUSH};
        tbl[8]  = '{"no_load",    mk(1'b0, 5'd7, 5'd7, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0), C_IDLE};
        tbl[9]  = '{"flush_div",  mk(1'b0, 5'd1, 5'd2, 1'b1, 1'b1, 5'd5, 1'b0, 1'b1, 1'b1), C_FLUSH};
        tbl[10] = '{"after_fd",   idle_s, C_IDLE};
        b2b_exp[0] = C_HOLD; b2b_exp[1] = C_DONE; b2b_exp[2] = C_HOLD; b2b_exp[3] = C_DONE;

        drive(tbl[0].s);
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            div_end[k] = -1; m_stall[k] = 0; m_flush[k] = 0;
        end

        for (int i = 0; i < 11; i++) begin
            step(tbl[i].s, 1'b1, 1'b1, tbl[i].exp, tbl[i].name);
        end

        // Divide with EX_DIV_START held for the full occupancy on the DIV_CYCLES=32 instance.
        begin
            int done_at;
            int n_done;
            int n_busy;
            int st0;
            done_at = -1; n_done = 0; n_busy = 0;
            st0 = int'(if32.STALL_COUNT);
            for (int j = 0; j < 32; j++) begin
                step(div_s, 1'b1, 1'b0, 8'd0, "");
                if (obs32[0]) begin
                    done_at = j;
                    n_done++;
                end
                if (obs32[1]) n_busy++;
            end
            check("div32_done_cycle", 32'(done_at), 32'd31);
            check("div32_done_pulses", 32'(n_done), 32'd1);
            check("div32_busy_cycles", 32'(n_busy), 32'd31);
            check("div32_stall_delta", 32'(int'(if32.STALL_COUNT) - st0), STATS ? 32'd31 : 32'd0);
            step(idle_s, 1'b1, 1'b0, 8'd0, "");
            check("div32_run_after", 32'(obs32), 32'(C_IDLE));
        end

        // Reset ten cycles into a divide: no DIV_DONE, RUN afterwards, counters cleared.
        begin
            int n_done;
            n_done = 0;
            for (int j = 0; j < 10; j++) begin
                step(div_s, 1'b1, 1'b0, 8'd0, "");
                if (obs32[0]) n_done++;
            end
            step(mk(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b1), 1'b1, 1'b0, 8'd0, "");
            check("rst_mid_div_outputs", 32'(obs32), 32'(C_RESET));
            step(idle_s, 1'b1, 1'b0, 8'd0, "");
            if (obs32[0]) n_done++;
            check("rst_mid_div_run", 32'(obs32), 32'(C_IDLE));
            check("rst_mid_div_no_done", 32'(n_done), 32'd0);
            check("rst_mid_div_stall_cnt", 32'(if32.STALL_COUNT), 32'd0);
        end

        // Back-to-back divides on the DIV_CYCLES=2 instance.
        for (int j = 0; j < 4; j++) begin
            step(div_s, 1'b1, 1'b0, 8'd0, "");
            check("div2_b2b", 32'(obs2), 32'(b2b_exp[j]));
        end
        step(mk(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0), 1'b1, 1'b0, 8'd0, "");

        // Randomized traffic with small register numbers to provoke matches.
        for (int j = 0; j < 3000; j++) begin
            rs = mk($urandom_range(0, 99) == 0,
                    5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                    $urandom_range(0, 5) == 0, $urandom_range(0, 19) == 0);
            step(rs, 1'b1, 1'b0, 8'd0, "");
        end

`ifdef HAZARD_STATS_EN
        // Saturation: 70000 continuous load-use stalls.
        rs = mk(1'b0, 5'd5, 5'd5, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);
        for (int j = 0; j < 70000; j++) begin
            step(rs, 1'b0, 1'b0, 8'd0, "");
        end
        check("stall_saturated", 32'(if32.STALL_COUNT), 32'h0000_FFFF);
        step(rs, 1'b1, 1'b0, 8'd0, "");
        check("stall_no_wrap", 32'(if32.STALL_COUNT), 32'h0000_FFFF);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
